// File: rtl/risc_pkg.sv
// Shared register-file widths and the writeback request record.
package risc_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Request channels (load and ALU results) plus the register-file write port.
interface writeback_queue_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] wtd;
    logic [AW-1:0] wta;
    logic          cnt;

    modport master (
        output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
        input  mem_ready, alu_ready, wtd, wta, cnt
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
        output mem_ready, alu_ready, wtd, wta, cnt
    );
endinterface

// File: rtl/wb_match.sv
// Associative search over age-ordered queue entries; index 0 is oldest, so the last
// match found is the youngest.
module wb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic [AW-1:0]    addr_i [DEPTH],
    input  logic [DW-1:0]    data_i [DEPTH],
    input  logic [DEPTH-1:0] valid_i,
    input  logic [AW-1:0]    query_i,
    output logic             hit_o,
    output logic [DW-1:0]    data_o
);
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (query_i != '0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_i[i] && (addr_i[i] == query_i)) begin
                    hit_o  = 1'b1;
                    data_o = data_i[i];
                end
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// Circular writeback queue merging load and ALU results into one register-file write
// port, with forwarding lookup for two read addresses.
module writeback_queue
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW,
    parameter int unsigned DW    = REG_DW,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    writeback_queue_if.slave    bus,
    input  logic [AW-1:0]       rsa,
    input  logic [AW-1:0]       rta,
    output logic                rs_hit,
    output logic                rt_hit,
    output logic [DW-1:0]       rs_fwd,
    output logic [DW-1:0]       rt_fwd,
    output logic [CW-1:0]       count
);
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
    logic [CW-1:0] count_q, count_d, free;
    logic          cnt_q, cnt_d;
    logic [AW-1:0] wta_q, wta_d;
    logic [DW-1:0] wtd_q, wtd_d;

    logic mem_rdy, alu_rdy, mem_push, alu_push, pop;

    // Free slots come from the registered count: a same-cycle pop gives no credit.
    always_comb begin
        free     = CW'(DEPTH) - count_q;
        mem_rdy  = count_q < CW'(DEPTH);
        mem_push = bus.mem_valid && mem_rdy && (bus.mem_addr != '0);
        alu_rdy  = mem_push ? (free >= CW'(2)) : (free != '0);
        alu_push = bus.alu_valid && alu_rdy && (bus.alu_addr != '0);
        pop      = count_q != '0;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        alu_slot = mem_push ? tail_q + PW'(1) : tail_q;
        if (mem_push) begin
            addr_d[tail_q] = bus.mem_addr;
            data_d[tail_q] = bus.mem_data;
        end
        if (alu_push) begin
            addr_d[alu_slot] = bus.alu_addr;
            data_d[alu_slot] = bus.alu_data;
        end
        tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
        head_d  = pop ? head_q + PW'(1) : head_q;
        count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        cnt_d   = pop;
        wta_d   = pop ? addr_q[head_q] : wta_q;
        wtd_d   = pop ? data_q[head_q] : wtd_q;
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cnt_q   <= 1'b0;
            wta_q   <= '0;
            wtd_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            wta_q   <= wta_d;
            wtd_q   <= wtd_d;
        end
    end

    // Present entries oldest-first so the matcher can let the youngest win.
    logic [AW-1:0]    ord_addr [DEPTH];
    logic [DW-1:0]    ord_data [DEPTH];
    logic [DEPTH-1:0] ord_valid;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ord_addr[i]  = addr_q[head_q + PW'(i)];
            ord_data[i]  = data_q[head_q + PW'(i)];
            ord_valid[i] = CW'(i) < count_q;
        end
    end

    wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rs_match (
        .addr_i  (ord_addr),
        .data_i  (ord_data),
        .valid_i (ord_valid),
        .query_i (rsa),
        .hit_o   (rs_hit),
        .data_o  (rs_fwd)
    );

    wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rt_match (
        .addr_i  (ord_addr),
        .data_i  (ord_data),
        .valid_i (ord_valid),
        .query_i (rta),
        .hit_o   (rt_hit),
        .data_o  (rt_fwd)
    );

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.cnt       = cnt_q;
    assign bus.wta       = wta_q;
    assign bus.wtd       = wtd_q;
    assign count         = count_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_writeback_queue;
    import risc_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rsa, rta;
    logic        rs_hit, rt_hit;
    logic [31:0] rs_fwd, rt_fwd;
    logic [2:0]  count;

    writeback_queue_if #(.AW(5), .DW(32)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .rsa    (rsa),
        .rta    (rta),
        .rs_hit (rs_hit),
        .rt_hit (rt_hit),
        .rs_fwd (rs_fwd),
        .rt_fwd (rt_fwd),
        .count  (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wb_req_t     mq[$];
    logic        exp_cnt;
    logic [4:0]  exp_wta;
    logic [31:0] exp_wtd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] qs, input logic [4:0] qt);
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        rsa           = qs;
        rta           = qt;
    endtask

    function automatic void model_lookup(input logic [4:0] a, output logic h,
                                         output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].addr == a) begin
                    h = 1'b1;
                    d = mq[i].data;
                end
            end
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_cnt = 1'b0;
        exp_wta = '0;
        exp_wtd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus checked against the reference model, then advanced.
    task automatic run_cycle(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                             input logic av, input logic [4:0] aa, input logic [31:0] ad,
                             input logic [4:0] qs, input logic [4:0] qt);
        int          n;
        logic        er_m, er_a, push_m, push_a, eh;
        logic [31:0] ef;
        wb_req_t     r;
        drive(mv, ma, md, av, aa, ad, qs, qt);
        #1;
        n      = mq.size();
        er_m   = n < DEPTH;
        push_m = mv && er_m && (ma != 5'd0);
        er_a   = push_m ? (DEPTH - n >= 2) : (DEPTH - n >= 1);
        push_a = av && er_a && (aa != 5'd0);
        chk("mem_ready", 32'(bus.mem_ready), 32'(er_m));
        chk("alu_ready", 32'(bus.alu_ready), 32'(er_a));
        chk("count", 32'(count), 32'(n));
        chk("cnt", 32'(bus.cnt), 32'(exp_cnt));
        chk("wta", 32'(bus.wta), 32'(exp_wta));
        chk("wtd", bus.wtd, exp_wtd);
        model_lookup(qs, eh, ef);
        chk("rs_hit", 32'(rs_hit), 32'(eh));
        chk("rs_fwd", rs_fwd, ef);
        model_lookup(qt, eh, ef);
        chk("rt_hit", 32'(rt_hit), 32'(eh));
        chk("rt_fwd", rt_fwd, ef);
        @(posedge clk);
        if (n > 0) begin
            r       = mq.pop_front();
            exp_cnt = 1'b1;
            exp_wta = r.addr;
            exp_wtd = r.data;
        end else begin
            exp_cnt = 1'b0;
        end
        if (push_m) mq.push_back('{addr: ma, data: md});
        if (push_a) mq.push_back('{addr: aa, data: ad});
        #1;
    endtask

    typedef struct {
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [4:0]  qs, qt;
        logic [2:0]  e_count;
        logic        e_mr, e_ar, e_cnt;
        logic [4:0]  e_wta;
        logic [31:0] e_wtd;
        logic        e_rsh;
        logic [31:0] e_rsf;
        logic        e_rth;
        logic [31:0] e_rtf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single ALU write, mem+alu same register, then an r0 write that must vanish.
        tbl[0] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hAA, 5'd0, 5'd0,
                   3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0,
                   3'd1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'hAA, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3,
                   3'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hAA, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 5'd5, 5'd0,
                   3'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'hAA, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd3,
                   3'd2, 1'b1, 1'b1, 1'b0, 5'd3, 32'hAA, 1'b1, 32'h22, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                   3'd1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 32'h22, 1'b1, 32'h22};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                   3'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h22, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0,
                   3'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h22, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                   3'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h22, 1'b0, 32'h0, 1'b0, 32'h0};

        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        do_reset();

        for (int r = 0; r < 9; r++) begin
            drive(tbl[r].mv, tbl[r].ma, tbl[r].md, tbl[r].av, tbl[r].aa, tbl[r].ad,
                  tbl[r].qs, tbl[r].qt);
            #1;
            chk($sformatf("tbl%0d count", r), 32'(count), 32'(tbl[r].e_count));
            chk($sformatf("tbl%0d mem_ready", r), 32'(bus.mem_ready), 32'(tbl[r].e_mr));
            chk($sformatf("tbl%0d alu_ready", r), 32'(bus.alu_ready), 32'(tbl[r].e_ar));
            chk($sformatf("tbl%0d cnt", r), 32'(bus.cnt), 32'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d wta", r), 32'(bus.wta), 32'(tbl[r].e_wta));
            chk($sformatf("tbl%0d wtd", r), bus.wtd, tbl[r].e_wtd);
            chk($sformatf("tbl%0d rs_hit", r), 32'(rs_hit), 32'(tbl[r].e_rsh));
            chk($sformatf("tbl%0d rs_fwd", r), rs_fwd, tbl[r].e_rsf);
            chk($sformatf("tbl%0d rt_hit", r), 32'(rt_hit), 32'(tbl[r].e_rth));
            chk($sformatf("tbl%0d rt_fwd", r), rt_fwd, tbl[r].e_rtf);
            @(posedge clk);
            #1;
        end

        // Both requesters held valid: occupancy climbs 0,2,3,3 and alu is refused at 3.
        do_reset();
        begin
            logic [2:0] occ_exp [4];
            logic       ar_exp  [4];
            occ_exp = '{3'd0, 3'd2, 3'd3, 3'd3};
            ar_exp  = '{1'b1, 1'b1, 1'b0, 1'b0};
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, 5'(k + 1), 32'(k + 'h100), 1'b1, 5'(k + 9), 32'(k + 'h200),
                      5'd0, 5'd0);
                #1;
                chk($sformatf("fill%0d count", k), 32'(count), 32'(occ_exp[k]));
                chk($sformatf("fill%0d mem_ready", k), 32'(bus.mem_ready), 32'd1);
                chk($sformatf("fill%0d alu_ready", k), 32'(bus.alu_ready), 32'(ar_exp[k]));
                @(negedge clk);
                run_cycle(1'b1, 5'(k + 1), 32'(k + 'h100), 1'b1, 5'(k + 9), 32'(k + 'h200),
                          5'd0, 5'd0);
            end
            for (int k = 0; k < 6; k++)
                run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        end

        // Reset asserted mid-cycle with writes pending.
        do_reset();
        run_cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd0, 5'd0);
        run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst cnt", 32'(bus.cnt), 32'd0);
        chk("rst wta", 32'(bus.wta), 32'd0);
        chk("rst wtd", bus.wtd, 32'd0);
        chk("rst mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("rst alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst rs_hit", 32'(rs_hit), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++)
            run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);

        // Alternating pushes long enough to wrap the pointers several times.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0)
                run_cycle(1'b1, 5'((k % 7) + 1), 32'('h300 + k), 1'b0, 5'd0, 32'd0,
                          5'((k % 7) + 1), 5'd0);
            else
                run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'((k % 7) + 1), 32'('h400 + k),
                          5'd0, 5'((k % 7) + 1));
        end
        for (int k = 0; k < 6; k++)
            run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // Random traffic with a narrow address range to force forwarding collisions.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            run_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 Parameter AW, default 5, meaning register address width.
REQ-003 Parameter DW, default 32, meaning register data width.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 mem_valid  input  1  load-result write request.
REQ-008 mem_ready  output  1  load request accepted this cycle when high with mem_valid.
REQ-009 mem_addr  input  AW  load destination register.
REQ-010 mem_data  input  DW  load result.
REQ-011 alu_valid  input  1  ALU-result write request.
REQ-012 alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-013 alu_addr  input  AW  ALU destination register.
REQ-014 alu_data  input  DW  ALU result.
REQ-015 wtd  output  DW  register-file write data (registered).
REQ-016 wta  output  AW  register-file write address (registered).
REQ-017 cnt  output  1  register-file write enable (registered).
REQ-018 rsa, rta  input  AW each  read addresses presented to register file.
REQ-019 rs_hit, rt_hit  output  1 each  queued write pending to rsa / rta.
REQ-020 rs_fwd, rt_fwd  output  DW each  youngest queued data for rsa / rta; 0 when no hit.
REQ-021 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-022 Queue SHALL be FIFO-ordered, circular, head/tail pointers wrap modulo DEPTH.
REQ-023 Request with addr 0 SHALL be accepted (ready per REQ-025/026) and discarded, never enqueued.
REQ-024 mem_ready SHALL be high iff count < DEPTH.
REQ-025 alu_ready SHALL be high iff free slots >= 2 when mem request enqueues this cycle, else free slots >= 1.
REQ-026 Both accepted same cycle: mem entry SHALL be enqueued ahead of alu entry (mem is older instruction).
REQ-027 Free slots SHALL be computed from count before the current cycle's pop (no same-cycle pop credit).
REQ-028 Drain: each cycle with count > 0, head SHALL pop and register into wta/wtd with cnt=1 next cycle; else cnt=0, wta/wtd hold.
REQ-029 Latency: request accepted in cycle N into empty queue SHALL appear on cnt/wta/wtd in cycle N+2 (enqueue N+1, drain register N+2).
REQ-030 Push and pop in the same cycle SHALL both occur; count updates by pushes minus pop.
REQ-031 Lookup SHALL be combinational over valid queue entries only; youngest match wins.
REQ-032 rsa or rta equal 0 SHALL give hit=0, fwd=0.
REQ-033 Entry currently on wta/wtd is not searched; register-file same-cycle bypass covers it.
REQ-034 Overflow SHALL be impossible; full queue deasserts both readys.

Reset
REQ-035 rst SHALL immediately clear count, head, tail, cnt, wta, wtd to 0; entries' contents need not clear.
REQ-036 After reset mem_ready=1, alu_ready=1, rs_hit=rt_hit=0; in-flight writes are dropped.

Structure
REQ-037 Package risc_pkg SHALL hold REG_AW=5, REG_DW=32 and typedef wb_req_t {addr, data}.
REQ-038 Sub-module wb_match (entry array + valid mask + query addr -> hit, data) SHALL be instantiated twice (rs, rt).

Verification
REQ-039 Single ALU write r3=0x0000_00AA at cycle 0 -> cnt=1, wta=3, wtd=0xAA at cycle 2, once.
REQ-040 mem r5=0x11 and alu r5=0x22 same cycle -> writes r5=0x11 then r5=0x22 consecutive cycles; rs_fwd=0x22 while both queued.
REQ-041 alu r0=0xFF -> ready=1, count stays 0, cnt never asserts.
REQ-042 Fill DEPTH=4 without drain stall then hold both valids -> readys low at count=4; with 3 queued and both valid, only mem accepted.
REQ-043 Queue 2 entries, assert rst mid-cycle -> count=0, cnt=0 immediately, no further writes.
REQ-044 Continuous alternating pushes for 20 cycles -> pointer wrap, write order matches acceptance order exactly.
